// File: rtl/linebuf_ctrl_if.sv
// Sprite pixel handshake between the motion-object generator (master) and the line buffer.
// Valid/ready: a pixel transfers on any clock where pix_valid and pix_ready are both high;
// the master holds pix_x/pix_data stable while pix_valid is high and not yet accepted.
interface linebuf_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int PIX_W  = 4
);
    logic              pix_valid;
    logic              pix_ready;
    logic [ADDR_W-1:0] pix_x;
    logic [PIX_W-1:0]  pix_data;

    modport master (output pix_valid, output pix_x, output pix_data, input pix_ready);
    modport slave  (input pix_valid, input pix_x, input pix_data, output pix_ready);
endinterface

// File: rtl/linebuf_ctrl.sv
// Ping-pong sprite line buffer controller: one bank collects sprite pixels while the other
// is scanned out to video and cleared behind the beam.
module linebuf_ctrl #(
    parameter int ADDR_W = 8,
    parameter int PIX_W  = 4,
    parameter int TRANSP = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_start,
    input  logic              pix_ce,
    input  logic [ADDR_W-1:0] hcount,
    linebuf_ctrl_if.slave     pix,
    output logic [PIX_W-1:0]  out_pixel,
    output logic              out_valid,
    output logic [ADDR_W-1:0] ram_a_addr,
    output logic [PIX_W-1:0]  ram_a_din,
    input  logic [PIX_W-1:0]  ram_a_dout,
    output logic              ram_a_cs1_n,
    output logic              ram_a_w_n,
    output logic [ADDR_W-1:0] ram_b_addr,
    output logic [PIX_W-1:0]  ram_b_din,
    input  logic [PIX_W-1:0]  ram_b_dout,
    output logic              ram_b_cs1_n,
    output logic              ram_b_w_n,
    output logic              dbg_state
);
    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [PIX_W-1:0] TRANSP_V = PIX_W'(TRANSP);

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              sel;       // write bank; read bank is ~sel
    logic              rd_bank;   // bank latched by the last pix_ce
    logic              clr_pend;  // read address is on the bus; capture and clear next edge
    logic              cs1_n_q;
    logic [ADDR_W-1:0] addr_q [2];
    logic [PIX_W-1:0]  din_q  [2];
    logic              w_n_q  [2];
    logic              accept;

    assign pix.pix_ready = (state == ST_RUN) && !line_start;
    assign accept        = pix.pix_valid && pix.pix_ready;
    assign dbg_state     = state;

    assign ram_a_addr  = addr_q[0];
    assign ram_a_din   = din_q[0];
    assign ram_a_w_n   = w_n_q[0];
    assign ram_a_cs1_n = cs1_n_q;
    assign ram_b_addr  = addr_q[1];
    assign ram_b_din   = din_q[1];
    assign ram_b_w_n   = w_n_q[1];
    assign ram_b_cs1_n = cs1_n_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            sel       <= 1'b0;
            rd_bank   <= 1'b0;
            clr_pend  <= 1'b0;
            cs1_n_q   <= 1'b0;
            out_pixel <= '0;
            out_valid <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                addr_q[b] <= '0;
                din_q[b]  <= '0;
                w_n_q[b]  <= 1'b1;
            end
        end else begin
            out_valid <= 1'b0;
            clr_pend  <= 1'b0;
            cs1_n_q   <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    for (int b = 0; b < 2; b++) begin
                        addr_q[b] <= clr_cnt;
                        din_q[b]  <= '0;
                        w_n_q[b]  <= 1'b0;
                    end
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == '1) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (line_start) sel <= ~sel;
                    if (pix_ce) begin
                        rd_bank  <= ~sel;
                        clr_pend <= 1'b1;
                    end
                    if (clr_pend) begin
                        out_pixel <= rd_bank ? ram_b_dout : ram_a_dout;
                        out_valid <= 1'b1;
                    end
                    // A pending clear owns its bank even if a swap just made it the write bank.
                    for (int b = 0; b < 2; b++) begin
                        if (clr_pend && (rd_bank == 1'(b))) begin
                            din_q[b] <= '0;
                            w_n_q[b] <= 1'b0;
                        end else if (pix_ce && (~sel == 1'(b))) begin
                            addr_q[b] <= hcount;
                            din_q[b]  <= '0;
                            w_n_q[b]  <= 1'b1;
                        end else if (accept && (sel == 1'(b))) begin
                            addr_q[b] <= pix.pix_x;
                            din_q[b]  <= pix.pix_data;
                            w_n_q[b]  <= (pix.pix_data == TRANSP_V);
                        end else begin
                            w_n_q[b] <= 1'b1;
                        end
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_linebuf_ctrl.sv
// Bench for linebuf_ctrl: behavioural RAM banks, a line-level reference model and a scoreboard.
module tb_linebuf_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       line_start, pix_ce;
  logic [7:0] hcount;
  logic [3:0] out_pixel;
  logic       out_valid, dbg_state;
  logic [7:0] ram_a_addr, ram_b_addr;
  logic [3:0] ram_a_din, ram_b_din, ram_a_dout, ram_b_dout;
  logic       ram_a_cs1_n, ram_b_cs1_n, ram_a_w_n, ram_b_w_n;

  linebuf_ctrl_if #(.ADDR_W(8), .PIX_W(4)) pix_bus ();

  linebuf_ctrl dut (
    .clk(clk), .reset(reset), .line_start(line_start), .pix_ce(pix_ce), .hcount(hcount),
    .pix(pix_bus), .out_pixel(out_pixel), .out_valid(out_valid),
    .ram_a_addr(ram_a_addr), .ram_a_din(ram_a_din), .ram_a_dout(ram_a_dout),
    .ram_a_cs1_n(ram_a_cs1_n), .ram_a_w_n(ram_a_w_n),
    .ram_b_addr(ram_b_addr), .ram_b_din(ram_b_din), .ram_b_dout(ram_b_dout),
    .ram_b_cs1_n(ram_b_cs1_n), .ram_b_w_n(ram_b_w_n), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural 256x4 banks: write when selected and w_n low
  logic [3:0] mem_a [256];
  logic [3:0] mem_b [256];
  logic       scramble = 1'b0;
  int         a_strobes = 0;
  assign ram_a_dout = mem_a[ram_a_addr];
  assign ram_b_dout = mem_b[ram_b_addr];
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= 4'($urandom);
        mem_b[i] <= 4'($urandom);
      end
    end else begin
      if (!ram_a_cs1_n && !ram_a_w_n) begin
        mem_a[ram_a_addr] <= ram_a_din;
        a_strobes <= a_strobes + 1;
      end
      if (!ram_b_cs1_n && !ram_b_w_n) mem_b[ram_b_addr] <= ram_b_din;
    end
  end

  // reference model: logical line contents per bank, bank 0 = A
  logic [3:0]  ref_bank [2][256];
  bit          ref_sel;
  bit          running;
  logic [3:0]  exp_q [$];
  int unsigned exp_t [$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every out_valid strobe must match the oldest expected read, 2 clks after pix_ce
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) check("spurious_out_valid", 1, 0);
      else begin
        check("out_pixel", out_pixel, exp_q.pop_front());
        check("out_latency", cyc, exp_t.pop_front());
      end
    end
  end

  bit prev_ce = 1'b0;
  always @(posedge clk) prev_ce <= pix_ce;
  always @(negedge clk) if (!reset && pix_ce && prev_ce) check("ce_spacing", 1, 0);

  // driver tasks: inputs change 1 time unit after the active edge
  task automatic set_idle();
    line_start = 0; pix_ce = 0; hcount = 0;
    pix_bus.pix_valid = 0; pix_bus.pix_x = 0; pix_bus.pix_data = 0;
  endtask

  task automatic drive(input bit ls, input bit ce, input logic [7:0] h,
                       input bit pv, input logic [7:0] x, input logic [3:0] d, input bit drop);
    line_start = ls; pix_ce = ce; hcount = h;
    pix_bus.pix_valid = pv; pix_bus.pix_x = x; pix_bus.pix_data = d;
    #1;
    check("pix_ready", pix_bus.pix_ready, running && !ls);
    if (ce) begin
      exp_q.push_back(ref_bank[!ref_sel][h]);
      exp_t.push_back(cyc + 2);
      ref_bank[!ref_sel][h] = 4'h0;
    end
    if (pv && running && !ls && !drop && d != 4'h0) ref_bank[ref_sel][x] = d;
    if (ls) ref_sel = !ref_sel;
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // release reset and walk the 256-clk clear sweep with noise on the ignored inputs
  task automatic do_clear();
    int bad_out, bad_seq, nz;
    bad_out = 0; bad_seq = 0; nz = 0;
    running = 0;
    reset = 0;
    for (int i = 1; i <= 256; i++) begin
      if (i <= 250) begin
        line_start = 1'($urandom_range(0, 1));
        pix_ce = (i % 2 == 0);
        hcount = 8'($urandom);
        pix_bus.pix_valid = 1; pix_bus.pix_x = 8'($urandom); pix_bus.pix_data = 4'hF;
      end else set_idle();
      @(posedge clk); #1;
      if (ram_a_addr != 8'(i - 1) || ram_b_addr != 8'(i - 1) || ram_a_w_n || ram_b_w_n
          || ram_a_din != 0 || ram_b_din != 0) bad_seq++;
      if (i < 256 && (pix_bus.pix_ready || out_valid)) bad_out++;
    end
    check("clear_sweep", bad_seq, 0);
    check("clear_quiet", bad_out, 0);
    check("ready_rise", pix_bus.pix_ready, 1);
    check("state_run", dbg_state, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin
      if (mem_a[i] != 0) nz++;
      if (mem_b[i] != 0) nz++;
    end
    check("clear_all_zero", nz, 0);
    for (int i = 0; i < 256; i++) begin
      ref_bank[0][i] = 0;
      ref_bank[1][i] = 0;
    end
    ref_sel = 0;
    running = 1;
  endtask

  task automatic drain_and_compare(input string tag);
    int mis;
    mis = 0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check({tag, "_drain"}, exp_q.size(), 0);
    for (int i = 0; i < 256; i++) begin
      if (mem_a[i] !== ref_bank[0][i]) mis++;
      if (mem_b[i] !== ref_bank[1][i]) mis++;
    end
    check({tag, "_ram"}, mis, 0);
  endtask

  initial begin
    int w0, since_ce;
    bit ce;
    set_idle();
    reset = 1; running = 0;
    scramble = 1;
    @(posedge clk); #1;
    scramble = 0;
    repeat (2) begin @(posedge clk); #1; end
    check("rst_a_addr", ram_a_addr, 0);
    check("rst_b_din", ram_b_din, 0);
    check("rst_a_w_n", ram_a_w_n, 1);
    check("rst_b_w_n", ram_b_w_n, 1);
    check("rst_cs1_n", {ram_a_cs1_n, ram_b_cs1_n}, 0);
    check("rst_out", {out_valid, out_pixel}, 0);
    check("rst_ready", pix_bus.pix_ready, 0);
    check("rst_state", dbg_state, 0);
    do_clear();

    // x=10 d=5, x=11 transparent: exactly one bank A write strobe
    w0 = a_strobes;
    drive(0, 0, 0, 1, 10, 5, 0);
    drive(0, 0, 0, 1, 11, 0, 0);
    idle(1);
    check("transp_no_write", a_strobes - w0, 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 10, 0, 0, 0, 0); idle(1);
    drive(0, 1, 11, 0, 0, 0, 0); idle(3);
    check("clear_behind_beam", mem_a[10], 0);

    // two writes to x=20 in one line: the later wins
    drive(0, 0, 0, 1, 20, 3, 0);
    drive(0, 0, 0, 1, 20, 7, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 20, 0, 0, 0, 0); idle(3);

    // pixel offered on line_start is refused
    drive(1, 0, 0, 1, 30, 9, 0);
    check("ls_bank_untouched", mem_a[30], 0);
    drive(0, 1, 30, 0, 0, 0, 0); idle(3);

    // pix_ce then line_start next clk: read and clear stay on the old read bank
    drive(0, 0, 0, 1, 40, 12, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 40, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    idle(3);
    check("late_swap_clear", mem_b[40], 0);

    // swap with pix_ce in the same clk: next write lands on the clearing bank and is dropped
    drive(1, 1, 60, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 61, 6, 1);
    drive(0, 0, 0, 1, 62, 6, 0);
    idle(2);
    check("collision_drop", mem_a[61], 0);
    check("post_collision_write", mem_a[62], 6);
    drain_and_compare("directed");

    // randomized lines
    since_ce = 2;
    for (int l = 0; l < 40; l++) begin
      drive(1, 0, 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 4'($urandom), 0);
      since_ce = since_ce + 1;
      for (int c = 0; c < 24; c++) begin
        ce = (since_ce >= 2) && ($urandom_range(0, 2) != 0);
        drive(0, ce, 8'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 31)),
              ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom), 0);
        since_ce = ce ? 1 : since_ce + 1;
      end
    end
    drain_and_compare("random");

    // reset mid-line with data in both banks restarts the full clear
    drive(0, 0, 0, 1, 5, 4'hA, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 6, 4'hB, 0);
    reset = 1;
    repeat (2) begin @(posedge clk); #1; end
    check("midrst_state", dbg_state, 0);
    do_clear();
    drive(0, 0, 0, 1, 7, 4'h3, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 7, 0, 0, 0, 0); idle(3);
    drain_and_compare("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
